serial_adder_nb: RTL and testbench

//  Digit-serial N-bit adder/subtractor built from a DIGIT-bit ripple full-adder slice.

---
 rtl/serial_adder_nb_pkg.sv | 14 +
 rtl/serial_adder_nb_fa_digit.sv | 32 +++
 rtl/serial_adder_nb.sv | 119 +++++++++++
 tb/tb_serial_adder_nb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_nb_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and operating-mode constants.
package serial_adder_nb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_nb_pkg

// File: rtl/serial_adder_nb_fa_digit.sv
// DIGIT-bit ripple-carry slice built from 1-bit full-adder cells. Purely
// combinational. Also exports the carry into its top bit so the parent can
// form signed overflow on the final digit.
module fa_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through the cells, least-significant bit first.
    always_comb begin
        logic c;
        s        = '0;
        co       = 1'b0;
        c_msb_in = ci;
        c        = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule : fa_digit

// File: rtl/serial_adder_nb.sv
// Digit-serial N-bit adder/subtractor. Operands are captured on an accepted
// start, then DIGIT bits are summed per clock, LSD first, with the carry
// held in a register between cycles. done pulses for one cycle when the
// result is complete; sum/cout/ovf then hold until the next accepted start.
module serial_adder_nb
    import serial_adder_nb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_params
            $error("serial_adder_nb: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg, ovf_reg;

    logic [DIGIT-1:0] s_dig;
    logic             co_dig, cmsb_dig;
    logic [WIDTH-1:0] sum_shift;
    logic             last_digit, accept;

    assign last_digit = (cnt_reg == CW'(NDIG - 1));
    assign accept     = start && (state_reg == ST_IDLE || state_reg == ST_DONE);

    fa_digit #(.DIGIT(DIGIT)) u_slice (
        .a        (a_reg[DIGIT-1:0]),
        .b        (b_reg[DIGIT-1:0]),
        .ci       (carry_reg),
        .s        (s_dig),
        .co       (co_dig),
        .c_msb_in (cmsb_dig)
    );

    // New digit enters at the MSB end so the LSD ends up at bit 0 after NDIG shifts.
    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign sum_shift = {s_dig, sum_reg[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign sum_shift = s_dig;
        end
    endgenerate

    // State register; reset overrides everything, including a run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE or DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_digit) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one digit per RUN cycle otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= '0;
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= (sub == MODE_SUB) ? 1'b1 : cin;
        end else if (state_reg == ST_RUN) begin
            cnt_reg   <= cnt_reg + CW'(1);
            a_reg     <= a_reg >> DIGIT;
            b_reg     <= b_reg >> DIGIT;
            sum_reg   <= sum_shift;
            carry_reg <= co_dig;
            if (last_digit) begin
                cout_reg <= co_dig;
                ovf_reg  <= cmsb_dig ^ co_dig;
            end
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule : serial_adder_nb

// File: tb/tb_serial_adder_nb.sv
// Directed and small random checks of serial_adder_nb at WIDTH=8 with
// DIGIT=1 (bit-serial) and DIGIT=4. One line printed per operation.
module tb_serial_adder_nb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start1 = 0, sub1 = 0, cin1 = 0;
    logic [7:0] a1 = 0, b1 = 0;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;

    logic       start4 = 0, sub4 = 0, cin4 = 0;
    logic [7:0] a4 = 0, b4 = 0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    serial_adder_nb #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder_nb #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit cur_sel  = 0;

    logic       done_m, busy_m, cout_m, ovf_m;
    logic [7:0] sum_m;
    always_comb begin
        done_m = cur_sel ? done4 : done1;
        busy_m = cur_sel ? busy4 : busy1;
        sum_m  = cur_sel ? sum4  : sum1;
        cout_m = cur_sel ? cout4 : cout1;
        ovf_m  = cur_sel ? ovf4  : ovf1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done on the selected DUT; returns edges since the accepting edge.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_m) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb, input logic [7:0] es,
                         input logic ec, input logic eo, input int elat, input string tag);
        int lat;
        cur_sel = sel;
        @(negedge clk);
        if (sel) begin a4 = av; b4 = bv; cin4 = ci; sub4 = sb; start4 = 1; end
        else     begin a1 = av; b1 = bv; cin1 = ci; sub1 = sb; start1 = 1; end
        @(posedge clk);
        #1;
        start1 = 0;
        start4 = 0;
        wait_done(lat);
        $display("op %s dig=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, sel ? 4 : 1, av, bv, ci, sb, sum_m, cout_m, ovf_m, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_sum"}, sum_m, es);
        check({tag, "_cout"}, cout_m, ec);
        check({tag, "_ovf"}, ovf_m, eo);
        @(negedge clk);
        check({tag, "_pulse"}, done_m, 1'b0);
    endtask

    initial begin
        int lat;
        logic seen;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1", sum1, 0);
        check("rst_cout1", cout1, 0);
        check("rst_ovf1", ovf1, 0);
        check("rst_busy4", busy4, 0);
        check("rst_sum4", sum4, 0);
        rst = 0;

        // Directed vectors
        do_op(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 9, "t1_add");
        do_op(0, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 9, "t2_sub_ovf");
        do_op(0, 8'h01, 8'h02, 1, 1, 8'hFF, 0, 0, 9, "t2_sub_borrow");
        do_op(0, 8'h40, 8'h40, 0, 0, 8'h80, 0, 1, 9, "t1_posovf");
        do_op(1, 8'h7F, 8'h01, 1, 0, 8'h81, 0, 1, 3, "t3_add_cin");
        do_op(1, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 3, "t3_sub");
        do_op(1, 8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 3, "t3_digitcarry");

        // start held through RUN is ignored; start in DONE launches a second op
        cur_sel = 0;
        @(negedge clk);
        a1 = 8'h12; b1 = 8'h34; cin1 = 0; sub1 = 0; start1 = 1;
        @(posedge clk);
        #1;
        a1 = 8'h55; b1 = 8'h22;
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) check("t4_busy_mid", busy1, 1);
            if (done1) begin lat = k; break; end
        end
        $display("op t4_first sum=%h lat=%0d", sum1, lat);
        check("t4_first_lat", lat, 9);
        check("t4_first_sum", sum1, 8'h46);
        check("t4_done_notbusy", busy1, 0);
        @(posedge clk);
        #1;
        start1 = 0;
        check("t4_b2b_busy", busy1, 1);
        wait_done(lat);
        $display("op t4_second sum=%h lat=%0d", sum1, lat);
        check("t4_second_lat", lat, 9);
        check("t4_second_sum", sum1, 8'h77);

        // Reset mid-RUN discards the operation
        @(negedge clk);
        a1 = 8'h0F; b1 = 8'h01; start1 = 1;
        @(posedge clk);
        #1;
        start1 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("t5_busy", busy1, 0);
        check("t5_done", done1, 0);
        check("t5_sum", sum1, 0);
        check("t5_cout", cout1, 0);
        check("t5_ovf", ovf1, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen = seen | done1;
        end
        $display("op t5_reset_midrun done_seen=%0d", seen);
        check("t5_no_done", seen, 0);

        // Random operations against an arithmetic reference
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb, rbb, rs;
            logic       rc, rsb, ro;
            logic [8:0] full;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rsb  = 1'($urandom);
            rbb  = rsb ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, rbb} + {8'd0, (rsb ? 1'b1 : rc)};
            rs   = full[7:0];
            ro   = (ra[7] == rbb[7]) && (rs[7] != ra[7]);
            do_op(i[0], ra, rb, rc, rsb, rs, full[8], ro, i[0] ? 3 : 9, "t6_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_serial_adder_nb
